// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the ALU arbiter slice:
//   DATA_W / OP_W  : ALU operand and opcode widths
//   OP_*           : ALU opcode encodings, OP_MAX is the highest legal opcode
//   arb_state_e    : arbiter FSM state encoding (IDLE / EXEC / RESP)
//   op_illegal()   : flags opcodes beyond OP_MAX
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_AND  = 4'd2;
   localparam logic [OP_W-1:0] OP_OR   = 4'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
   localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
   localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
   localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
   localparam logic [OP_W-1:0] OP_ADDI = 4'd8;
   localparam logic [OP_W-1:0] OP_XORI = 4'd9;
   localparam logic [OP_W-1:0] OP_MAX  = OP_XORI;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Opcodes above OP_MAX still execute but are reported back as errors.
   function automatic logic op_illegal(input logic [OP_W-1:0] op);
      return (op > OP_MAX);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester channels, the shared response channel and the
// ALU connection of the ALU arbiter.
//   req0_* / req1_*  : valid/ready request channels (op, a, b)
//   rsp0_* / rsp1_*  : per-requester response valid/ready
//   rsp_*            : shared registered result, flags and error
//   alu_*            : drive to / result from the combinational ALU
//   ovf_sticky/ovf_clr : present only when ALU_ARB_STICKY_OVF_EN is defined
// Modports: slave = the arbiter, master = CPU control logic plus ALU.
// -----------------------------------------------------------------------------
interface alu_arbiter_if;
   import cpu_pkg::*;

   logic              req0_valid;
   logic              req0_ready;
   logic [OP_W-1:0]   req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;

   logic              req1_valid;
   logic              req1_ready;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;

   logic              rsp0_valid;
   logic              rsp0_ready;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic              rsp_ovf;
   logic              rsp_err;

   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_ovf;

`ifdef ALU_ARB_STICKY_OVF_EN
   logic [1:0]        ovf_sticky;
   logic [1:0]        ovf_clr;
`endif

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready,
      input  alu_result, alu_zero, alu_ovf,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid,
      output rsp_result, rsp_zero, rsp_ovf, rsp_err,
      output alu_op, alu_a, alu_b
`ifdef ALU_ARB_STICKY_OVF_EN
      ,
      output ovf_sticky,
      input  ovf_clr
`endif
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp0_ready, rsp1_ready,
      output alu_result, alu_zero, alu_ovf,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid,
      input  rsp_result, rsp_zero, rsp_ovf, rsp_err,
      input  alu_op, alu_a, alu_b
`ifdef ALU_ARB_STICKY_OVF_EN
      ,
      input  ovf_sticky,
      output ovf_clr
`endif
   );

endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-input round-robin selector.
//   valid_i[1:0]  : request valids
//   last_grant_i  : requester served most recently
//   winner_o      : selected requester (0 when nothing is valid)
//   any_valid_o   : at least one requester is valid
// -----------------------------------------------------------------------------
module rr_pick2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       winner_o,
   output logic       any_valid_o
);

   // Lone requester wins outright; on contention the one not served last wins.
   always_comb begin
      any_valid_o = |valid_i;
      case (valid_i)
         2'b01:   winner_o = 1'b0;
         2'b10:   winner_o = 1'b1;
         2'b11:   winner_o = ~last_grant_i;
         default: winner_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational 8-bit ALU between requester 0 (instruction execute)
// and requester 1 (address/auxiliary) using round-robin arbitration.
// Flow: IDLE accepts the winner and latches op/a/b, EXEC drives the ALU for
// one cycle and registers result/flags, RESP holds the response for the owner
// until it is accepted.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_arbiter_if.slave (request, response and ALU signals)
// Optional feature macro: ALU_ARB_STICKY_OVF_EN adds per-requester sticky
// overflow bits (bus.ovf_sticky) with clear inputs (bus.ovf_clr).
// -----------------------------------------------------------------------------
module alu_arbiter
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus
);

   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic              ovf_q, ovf_d;

   logic              winner_s;
   logic              any_valid_s;
   logic [OP_W-1:0]   win_op_s;
   logic [DATA_W-1:0] win_a_s;
   logic [DATA_W-1:0] win_b_s;
   logic              rsp_ready_s;
   logic              idle_s;

   rr_pick2 u_pick (
      .valid_i      ({bus.req1_valid, bus.req0_valid}),
      .last_grant_i (last_grant_q),
      .winner_o     (winner_s),
      .any_valid_o  (any_valid_s)
   );

   // Reset is folded in so ready reads 0 while reset is held.
   assign idle_s = (state_q == IDLE) && !rst;

   assign bus.req0_ready = idle_s && !winner_s && bus.req0_valid;
   assign bus.req1_ready = idle_s &&  winner_s && bus.req1_valid;
   assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
   assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_zero   = zero_q;
   assign bus.rsp_ovf    = ovf_q;
   assign bus.rsp_err    = err_q;
   // ALU inputs come straight from the latched operands, so they only change
   // on an accept and stay quiet in IDLE and RESP.
   assign bus.alu_op     = op_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;

   // Payload of the current winner and response ready of the current owner.
   always_comb begin
      if (winner_s) begin
         win_op_s = bus.req1_op;
         win_a_s  = bus.req1_a;
         win_b_s  = bus.req1_b;
      end else begin
         win_op_s = bus.req0_op;
         win_a_s  = bus.req0_a;
         win_b_s  = bus.req0_b;
      end
      if (owner_q) begin
         rsp_ready_s = bus.rsp1_ready;
      end else begin
         rsp_ready_s = bus.rsp0_ready;
      end
   end

   // Next-state and datapath-register logic for the IDLE/EXEC/RESP FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      err_d        = err_q;
      result_d     = result_q;
      zero_d       = zero_q;
      ovf_d        = ovf_q;
      case (state_q)
         IDLE: begin
            // In IDLE the winner is always valid, so any_valid means accept.
            if (any_valid_s) begin
               owner_d = winner_s;
               op_d    = win_op_s;
               a_d     = win_a_s;
               b_d     = win_b_s;
               err_d   = op_illegal(win_op_s);
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            result_d = bus.alu_result;
            zero_d   = bus.alu_zero;
            ovf_d    = bus.alu_ovf;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready_s) begin
               last_grant_d = owner_q;
               state_d      = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_q         <= 4'd0;
         a_q          <= 8'h00;
         b_q          <= 8'h00;
         err_q        <= 1'b0;
         result_q     <= 8'h00;
         zero_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         err_q        <= err_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         ovf_q        <= ovf_d;
      end
   end

`ifdef ALU_ARB_STICKY_OVF_EN
   logic [1:0] sticky_q, sticky_d;
   logic [1:0] sticky_set_s;

   // A set on the same edge as a clear wins.
   always_comb begin
      sticky_set_s = 2'b00;
      if ((state_q == RESP) && rsp_ready_s && ovf_q) begin
         sticky_set_s[owner_q] = 1'b1;
      end else begin
         sticky_set_s = 2'b00;
      end
      sticky_d = (sticky_q & ~bus.ovf_clr) | sticky_set_s;
   end

   // Sticky overflow register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 2'b00;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign bus.ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arbiter_if bus();

   alu_arbiter u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference combinational ALU (environment model).
   logic [7:0] alu_res_s;
   logic       alu_ovf_s;
   always_comb begin
      alu_res_s = 8'h00;
      alu_ovf_s = 1'b0;
      case (bus.alu_op)
         4'd0, 4'd8: begin
            alu_res_s = bus.alu_a + bus.alu_b;
            alu_ovf_s = (bus.alu_a[7] == bus.alu_b[7]) && (alu_res_s[7] != bus.alu_a[7]);
         end
         4'd1: begin
            alu_res_s = bus.alu_a - bus.alu_b;
            alu_ovf_s = (bus.alu_a[7] != bus.alu_b[7]) && (alu_res_s[7] != bus.alu_a[7]);
         end
         4'd2:       alu_res_s = bus.alu_a & bus.alu_b;
         4'd3:       alu_res_s = bus.alu_a | bus.alu_b;
         4'd4, 4'd9: alu_res_s = bus.alu_a ^ bus.alu_b;
         4'd5:       alu_res_s = ~bus.alu_a;
         4'd6:       alu_res_s = bus.alu_a << 1;
         4'd7:       alu_res_s = bus.alu_a >> 1;
         default:    alu_res_s = 8'h00;
      endcase
   end
   assign bus.alu_result = alu_res_s;
   assign bus.alu_zero   = (alu_res_s == 8'h00);
   assign bus.alu_ovf    = alu_ovf_s;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       who;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       zero;
      logic       ovf;
      logic       err;
   } vec_t;

   vec_t vecs[8];

   task automatic set_req(input logic who, input logic v, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b);
      if (who) begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end
   endtask

   function automatic logic rdy(input logic who);
      return who ? bus.req1_ready : bus.req0_ready;
   endfunction

   function automatic logic rvld(input logic who);
      return who ? bus.rsp1_valid : bus.rsp0_valid;
   endfunction

   // One operation on a single requester with response accepted immediately.
   task automatic run_op(input vec_t v, input int idx);
      int    waited;
      string t;
      t = $sformatf("vec%0d", idx);
      @(posedge clk); #1;
      set_req(v.who, 1'b1, v.op, v.a, v.b);
      @(negedge clk);
      waited = 0;
      while (!rdy(v.who) && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk({t, " req_ready"}, rdy(v.who), 1'b1);
      @(posedge clk); #1;
      set_req(v.who, 1'b0, v.op, v.a, v.b);
      @(negedge clk);
      chk({t, " exec_no_rsp"}, rvld(v.who), 1'b0);
      @(negedge clk);
      chk({t, " rsp_valid"}, rvld(v.who), 1'b1);
      chk({t, " other_valid"}, rvld(!v.who), 1'b0);
      chk({t, " result"}, bus.rsp_result, v.res);
      chk({t, " zero"}, bus.rsp_zero, v.zero);
      chk({t, " ovf"}, bus.rsp_ovf, v.ovf);
      chk({t, " err"}, bus.rsp_err, v.err);
      if (v.who) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      @(negedge clk);
      chk({t, " rsp_done"}, rvld(v.who), 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   grants;
      int   cyc;
      int   last_cyc;
      logic exp_who;

      vecs[0] = '{1'b0, 4'd0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 4'd3, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 4'hC, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 4'd4, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 4'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 4'd9, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 4'hA, 8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 1'b1};

      rst = 1'b1;
      set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      set_req(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
`ifdef ALU_ARB_STICKY_OVF_EN
      bus.ovf_clr = 2'b00;
`endif

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst req0_ready", bus.req0_ready, 1'b0);
      chk("rst req1_ready", bus.req1_ready, 1'b0);
      chk("rst rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("rst rsp1_valid", bus.rsp1_valid, 1'b0);
      chk("rst rsp_result", bus.rsp_result, 8'h00);
      chk("rst rsp_zero", bus.rsp_zero, 1'b0);
      chk("rst rsp_ovf", bus.rsp_ovf, 1'b0);
      chk("rst rsp_err", bus.rsp_err, 1'b0);
      chk("rst alu_op", bus.alu_op, 4'd0);
      chk("rst alu_a", bus.alu_a, 8'h00);
      chk("rst alu_b", bus.alu_b, 8'h00);
      rst = 1'b0;

      // A: first contention after reset goes to req0.
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'd1, 8'h80, 8'h01);
      set_req(1'b1, 1'b1, 4'd2, 8'hF0, 8'h0F);
      @(negedge clk);
      chk("A req0_ready", bus.req0_ready, 1'b1);
      chk("A req1_ready", bus.req1_ready, 1'b0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("A exec req1_ready", bus.req1_ready, 1'b0);
      @(negedge clk);
      chk("A rsp0_valid", bus.rsp0_valid, 1'b1);
      chk("A rsp1_valid", bus.rsp1_valid, 1'b0);
      chk("A sub result", bus.rsp_result, 8'h7F);
      chk("A sub ovf", bus.rsp_ovf, 1'b1);
      chk("A sub zero", bus.rsp_zero, 1'b0);
      bus.rsp0_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b0;
      @(negedge clk);
      chk("A req1_ready next", bus.req1_ready, 1'b1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("A rsp1_valid", bus.rsp1_valid, 1'b1);
      chk("A rsp0_valid off", bus.rsp0_valid, 1'b0);
      chk("A and result", bus.rsp_result, 8'h00);
      chk("A and zero", bus.rsp_zero, 1'b1);
      chk("A and ovf", bus.rsp_ovf, 1'b0);
      bus.rsp1_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp1_ready = 1'b0;

`ifdef ALU_ARB_STICKY_OVF_EN
      @(negedge clk);
      chk("sticky set", bus.ovf_sticky, 2'b01);
      bus.ovf_clr = 2'b01;
      @(posedge clk); #1;
      bus.ovf_clr = 2'b00;
      @(negedge clk);
      chk("sticky clr", bus.ovf_sticky, 2'b00);
`endif

      // B: both held valid for 6 operations, responses accepted at once.
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'd0, 8'h01, 8'h01);
      set_req(1'b1, 1'b1, 4'd0, 8'h02, 8'h02);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      grants   = 0;
      cyc      = 0;
      last_cyc = 0;
      exp_who  = 1'b0;
      while (grants < 6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.req0_ready || bus.req1_ready) begin
            chk($sformatf("B grant%0d who", grants), bus.req1_ready, exp_who);
            if (grants > 0) chk($sformatf("B grant%0d spacing", grants), cyc - last_cyc, 3);
            last_cyc = cyc;
            exp_who  = ~exp_who;
            grants++;
            if (grants == 6) begin
               @(posedge clk); #1;
               bus.req0_valid = 1'b0;
               bus.req1_valid = 1'b0;
            end
         end
      end
      chk("B grant count", grants, 6);
      repeat (4) @(negedge clk);
      chk("B drained rsp0", bus.rsp0_valid, 1'b0);
      chk("B drained rsp1", bus.rsp1_valid, 1'b0);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;

      // Table of single-requester operations.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i], i);
      end

      // C: req0 response stalled 5 cycles while req1 waits.
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'd0, 8'h10, 8'h20);
      bus.rsp1_ready = 1'b1;
      @(negedge clk);
      chk("C req0_ready", bus.req0_ready, 1'b1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      set_req(1'b1, 1'b1, 4'd4, 8'h0F, 8'h0F);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("C stall%0d rsp0_valid", i), bus.rsp0_valid, 1'b1);
         chk($sformatf("C stall%0d result", i), bus.rsp_result, 8'h30);
         chk($sformatf("C stall%0d req1_ready", i), bus.req1_ready, 1'b0);
         chk($sformatf("C stall%0d rsp1_valid", i), bus.rsp1_valid, 1'b0);
         @(negedge clk);
      end
      bus.rsp0_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b0;
      @(negedge clk);
      chk("C req1_ready after", bus.req1_ready, 1'b1);
      bus.req1_valid = 1'b0;
      bus.rsp1_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("C no accept rsp1", bus.rsp1_valid, 1'b0);
      chk("C no accept alu_op", bus.alu_op, 4'd0);

      // D: reset during EXEC drops the transaction; next contention to req0.
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'd0, 8'h33, 8'h44);
      @(negedge clk);
      chk("D req0_ready", bus.req0_ready, 1'b1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("D exec alu_a", bus.alu_a, 8'h33);
      set_req(1'b0, 1'b1, 4'd0, 8'h01, 8'h02);
      set_req(1'b1, 1'b1, 4'd1, 8'h09, 8'h01);
      rst = 1'b1;
      #1;
      chk("D rst alu_op", bus.alu_op, 4'd0);
      chk("D rst alu_a", bus.alu_a, 8'h00);
      chk("D rst alu_b", bus.alu_b, 8'h00);
      chk("D rst rsp_result", bus.rsp_result, 8'h00);
      chk("D rst rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("D rst req0_ready", bus.req0_ready, 1'b0);
      chk("D rst req1_ready", bus.req1_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("D post req0_ready", bus.req0_ready, 1'b1);
      chk("D post req1_ready", bus.req1_ready, 1'b0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("D no rsp0 %0d", i), bus.rsp0_valid, 1'b0);
         chk($sformatf("D no rsp1 %0d", i), bus.rsp1_valid, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters: requester 0 is the instruction-execute path and requester 1 is the address/auxiliary path. The block uses round-robin arbitration and valid/ready handshakes. It latches the winning operands, drives the ALU for one cycle, registers the result and flags, and holds the response for the owning requester until that requester accepts it. It sits between the CPU control logic and the combinational ALU.

Parameters:
DATA_W, 8, operand/result width; must match the ALU.
OP_W, 4, ALU opcode width.
OP_MAX, 4'd9, highest legal ALU opcode (XORI); any opcode above it is illegal.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req0_valid  in  1  requester 0 has an operation pending.
req0_ready  out  1  requester 0's operation is accepted this cycle.
req0_op  in  OP_W  ALU opcode for requester 0.
req0_a, req0_b  in  DATA_W  operands for requester 0.
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
rsp0_valid  out  1  response for requester 0 is available.
rsp0_ready  in  1  requester 0 accepts the response.
rsp1_valid  out  1  response for requester 1 is available.
rsp1_ready  in  1  requester 1 accepts the response.
rsp_result  out  DATA_W  registered ALU result; shared by both response channels.
rsp_zero, rsp_ovf  out  1  registered zero and overflow flags.
rsp_err  out  1  the accepted opcode was greater than OP_MAX.
alu_op  out  OP_W  opcode driven to the ALU.
alu_a, alu_b  out  DATA_W  operands driven to the ALU.
alu_result  in  DATA_W  ALU result (combinational).
alu_zero, alu_ovf  in  1  ALU flags (combinational).

Behaviour:
- Reset is asynchronous and active-high on the single clock. Reset values:
  - state = IDLE, last_grant = 1.
  - All ready and valid outputs = 0.
  - rsp_result = 0, rsp_zero = 0, rsp_ovf = 0, rsp_err = 0.
  - alu_op = 0, alu_a = 0, alu_b = 0.
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE, winner selection (combinational):
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester that is not last_grant. Requester 0 therefore wins the first contention after reset.
- IDLE, handshake:
  - reqN_ready = (state == IDLE) && (winner == N) && reqN_valid.
  - On a ready&&valid edge, latch op/a/b and owner = N, set err = (op > OP_MAX), and go to EXEC.
- IDLE, no request: with no valid requester, stay in IDLE.
- EXEC:
  - alu_op/alu_a/alu_b are driven from the latched registers.
  - At the end of the cycle, capture alu_result/alu_zero/alu_ovf into the rsp_* registers and go to RESP.
- In IDLE and RESP, the ALU inputs hold their last latched values; no toggling.
- RESP:
  - rsp<owner>_valid = 1; the other response valid stays 0.
  - rsp_result and the flags stay stable until the handshake.
  - On rsp<owner>_ready, set last_grant = owner and go to IDLE.
- Latency and throughput:
  - Request accepted at edge T, response valid from edge T+2.
  - Minimum spacing is 3 cycles per operation.
- Requesters must hold valid and payload stable until ready is asserted. No request is accepted while in EXEC or RESP.
- Illegal opcode: the operation still executes; the ALU returns 0 (zero = 1, ovf = 0), and rsp_err = 1 is returned with the response.
- A response ready asserted while its valid is low is ignored.
- Asynchronous reset during EXEC or RESP drops the in-flight transaction; no response is produced.
- Arithmetic is performed entirely in the ALU; this block adds no width extension or modification of the result.

Optional Feature:
ALU_ARB_STICKY_OVF_EN
- Enabled:
  - Adds ports ovf_sticky out 2 and ovf_clr in 2.
  - ovf_sticky[N] sets when a response with rsp_ovf = 1 completes its handshake to requester N.
  - ovf_sticky[N] clears on ovf_clr[N]; if set and clear occur on the same edge, set wins. Reset value is 0.
- Disabled: those ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode localparams (OP_ADD = 0 through OP_XORI = 9) and OP_MAX.
  - DATA_W and OP_W.
  - The arbiter state typedef (IDLE/EXEC/RESP).
- Natural sub-module rr_pick2: a two-input round-robin selector taking valid[1:0] and last_grant and producing winner and any_valid. It is instantiated once.
- The FSM and the registers stay in alu_arbiter.

Test Plan:
- Only req0 issues ADD 8'h05 + 8'h03 -> req0_ready at T; rsp0_valid at T+2 with result 8'h08, zero = 0, ovf = 0, err = 0; rsp1_valid stays 0.
- Both valid after reset; req0 issues SUB 8'h80 - 8'h01, req1 issues AND 8'hF0 & 8'h0F:
  - req0 is granted first and gets result 8'h7F with ovf = 1.
  - req1 is granted next and gets result 8'h00 with zero = 1.
- Both requesters held continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1, with every accept spaced exactly 3 cycles apart when rsp_ready is held high.
- rsp0_ready held low for 5 cycles -> rsp0_valid and rsp_result stay stable, req1_ready stays 0 throughout, and no new accept occurs.
- req1 issues opcode 4'hC -> result 8'h00, zero = 1, rsp_err = 1.
- rst pulsed mid-EXEC -> all outputs return to reset values immediately; no response is produced; the next contention grants req0 first.
